// File: rtl/router_dest_reader.sv
// Destination-side reader for one router output port: drains packets from the port FIFO,
// checks parity and reports per-packet status. Define ROUTER_RD_STATS_EN for statistics counters.
module router_dest_reader #(
    parameter int unsigned RD_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_out,
    input  logic [7:0]  data_out,
    input  logic        soft_rst,
    output logic        rd_en,
    output logic        busy,
    output logic        pkt_done,
    output logic        parity_err,
    output logic        pkt_drop,
    output logic [1:0]  pkt_addr,
    output logic [5:0]  pkt_len,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StWait, StRead, StDone} state_e;

    state_e     state_q, state_d;
    logic [4:0] dly_q, dly_d;
    logic [6:0] issued_q, issued_d;
    logic [6:0] cap_q, cap_d;
    logic [7:0] xor_q, xor_d;
    logic       rd_q, rd_d;
    logic       perr_q, perr_d;
    logic       drop_q, drop_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] len_q, len_d;
    logic [6:0] parity_idx;
    logic [6:0] target;
    logic       abort;

    assign parity_idx = {1'b0, len_q} + 7'd1;
    // Only the header is requested until its length field has been captured.
    assign target     = (cap_q == 7'd0) ? 7'd1 : parity_idx + 7'd1;
    assign abort      = soft_rst && (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        issued_d = issued_q;
        cap_d    = cap_q;
        xor_d    = xor_q;
        perr_d   = perr_q;
        drop_d   = 1'b0;
        addr_d   = addr_q;
        len_d    = len_q;
        rd_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (vld_out) begin
                    issued_d = '0;
                    cap_d    = '0;
                    xor_d    = '0;
                    perr_d   = 1'b0;
                    if (RD_DELAY == 0) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWait;
                        dly_d   = 5'(RD_DELAY);
                    end
                end
            end
            StWait: begin
                dly_d = dly_q - 5'd1;
                if (dly_q <= 5'd1) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                rd_en = vld_out && (issued_q < target);
                if (rd_en) begin
                    issued_d = issued_q + 7'd1;
                end
                // Bytes arrive one cycle after their read strobe.
                if (rd_q) begin
                    cap_d = cap_q + 7'd1;
                    if (cap_q == 7'd0) begin
                        len_d  = data_out[7:2];
                        addr_d = data_out[1:0];
                        xor_d  = data_out;
                    end else if (cap_q == parity_idx) begin
                        perr_d  = (data_out != xor_q);
                        state_d = StDone;
                    end else begin
                        xor_d = xor_q ^ data_out;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Soft reset beats everything in flight, including a same-cycle parity capture.
        if (abort) begin
            state_d  = StIdle;
            dly_d    = '0;
            issued_d = '0;
            cap_d    = '0;
            xor_d    = '0;
            perr_d   = 1'b0;
            drop_d   = 1'b1;
        end

        rd_d = rd_en && !abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            dly_q    <= '0;
            issued_q <= '0;
            cap_q    <= '0;
            xor_q    <= '0;
            rd_q     <= 1'b0;
            perr_q   <= 1'b0;
            drop_q   <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            issued_q <= issued_d;
            cap_q    <= cap_d;
            xor_q    <= xor_d;
            rd_q     <= rd_d;
            perr_q   <= perr_d;
            drop_q   <= drop_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign pkt_done   = (state_q == StDone);
    assign parity_err = (state_q == StDone) && perr_q;
    assign pkt_drop   = drop_q;
    assign pkt_addr   = addr_q;
    assign pkt_len    = len_q;

`ifdef ROUTER_RD_STATS_EN
    logic [15:0] pkt_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (pkt_done) begin
            if (pkt_cnt_q != 16'hFFFF) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if (parity_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign pkt_cnt = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_router_dest_reader.sv
// Bench for router_dest_reader: an emulated port FIFO feeds packets built from the
// packet-format rules; per-packet results are compared against the generated expectations.
module tb_router_dest_reader;

    localparam int unsigned RD_DELAY = 2;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst, vld_out, soft_rst;
    logic [7:0]  data_out;
    logic        rd_en, busy, pkt_done, parity_err, pkt_drop;
    logic [1:0]  pkt_addr;
    logic [5:0]  pkt_len;
    logic [15:0] pkt_cnt, err_cnt;

    router_dest_reader #(.RD_DELAY(RD_DELAY)) dut (
        .clk        (clk),
        .rst        (rst),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .soft_rst   (soft_rst),
        .rd_en      (rd_en),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .pkt_drop   (pkt_drop),
        .pkt_addr   (pkt_addr),
        .pkt_len    (pkt_len),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] fifo[$];
    bit         stall;
    int         stall_seen;
    int         reads, dones, drops, viol;
    bit         timed_out;
    logic       rd_s, busy_s, done_s, perr_s, drop_s;
    logic [5:0] len_s;
    logic [1:0] addr_s;

    logic       exp_perr[$];
    logic [5:0] exp_len[$];
    logic [1:0] exp_addr[$];
    logic       got_perr[$];
    logic [5:0] got_len[$];
    logic [1:0] got_addr[$];
    int         got_pre[$];
    int         got_gap[$];
    int         exp_pkt, exp_err;

    function automatic logic [31:0] stats_model();
`ifdef ROUTER_RD_STATS_EN
        return {16'(exp_pkt), 16'(exp_err)};
`else
        return 32'h0;
`endif
    endfunction

    task automatic clear_model();
        exp_perr.delete();
        exp_len.delete();
        exp_addr.delete();
    endtask

    // Packet = header {len,addr}, len payload bytes, parity = XOR of all preceding bytes.
    task automatic push_pkt(input logic [7:0] hdr, input bq_t pl, input bit corrupt);
        logic [7:0] x;
        x = hdr;
        fifo.push_back(hdr);
        foreach (pl[i]) begin
            fifo.push_back(pl[i]);
            x ^= pl[i];
        end
        fifo.push_back(corrupt ? (x ^ 8'h01) : x);
        exp_perr.push_back(corrupt);
        exp_len.push_back(hdr[7:2]);
        exp_addr.push_back(hdr[1:0]);
    endtask

    task automatic push_rand(input int len, input bit corrupt);
        bq_t        pl;
        logic [1:0] addr;
        addr = 2'($urandom_range(0, 3));
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        push_pkt({6'(len), addr}, pl, corrupt);
    endtask

    // One clock: drive vld_out, sample outputs at negedge, then serve the read one cycle later.
    task automatic cycle();
        vld_out = (fifo.size() != 0) && !stall;
        @(negedge clk);
        rd_s   = rd_en;
        busy_s = busy;
        done_s = pkt_done;
        perr_s = parity_err;
        drop_s = pkt_drop;
        len_s  = pkt_len;
        addr_s = pkt_addr;
        if (rd_s && (!vld_out || !busy_s || done_s)) viol++;
        @(posedge clk);
        #1;
        if (rd_s) begin
            if (fifo.size() == 0) viol++;
            else begin
                data_out = fifo.pop_front();
                reads++;
            end
        end
        if (soft_rst || rst) fifo.delete();
    endtask

    task automatic run(input int n_pkts, input int stall_at, input int stall_len, input int max_cyc);
        int cyc, pre, gap;
        bit rd_started, after_done;
        cyc = 0; pre = 0; gap = 0; rd_started = 0; after_done = 0;
        reads = 0; dones = 0; drops = 0; viol = 0; stall_seen = 0;
        got_perr.delete(); got_len.delete(); got_addr.delete();
        got_pre.delete(); got_gap.delete();
        while (dones < n_pkts && cyc < max_cyc) begin
            stall = (stall_at >= 0) && (reads >= stall_at) && (stall_seen < stall_len);
            if (stall) stall_seen++;
            cycle();
            cyc++;
            if (busy_s && !rd_started && !rd_s) pre++;
            if (rd_s) rd_started = 1;
            if (drop_s) drops++;
            if (after_done) begin
                if (busy_s) begin
                    got_gap.push_back(gap);
                    after_done = 0;
                end else gap++;
            end
            if (done_s) begin
                got_perr.push_back(perr_s);
                got_len.push_back(len_s);
                got_addr.push_back(addr_s);
                got_pre.push_back(pre);
                dones++;
                pre = 0; rd_started = 0; after_done = 1; gap = 0;
            end
        end
        timed_out = (dones < n_pkts);
        stall = 0;
    endtask

    task automatic test_reset();
        rst = 1; soft_rst = 0; stall = 0; data_out = '0; fifo.delete();
        cycle();
        cycle();
        tests++;
        if ({rd_s, busy_s, done_s, perr_s, drop_s} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got=%b want=00000", {rd_s, busy_s, done_s, perr_s, drop_s});
        end
        tests++;
        if ({len_s, addr_s} !== 8'h00) begin
            fails++;
            $display("FAIL reset_hdr got len=%0d addr=%0d want 0/0", len_s, addr_s);
        end
        tests++;
        if ({pkt_cnt, err_cnt} !== 32'h0) begin
            fails++;
            $display("FAIL reset_stats got=%h/%h want 0/0", pkt_cnt, err_cnt);
        end
        rst = 0; exp_pkt = 0; exp_err = 0;
    endtask

    task automatic test_basic(input bit corrupt);
        bq_t pl;
        pl = {8'h11, 8'h22, 8'h33};
        clear_model();
        push_pkt(8'h0D, pl, corrupt);
        run(1, -1, 0, 200);
        tests++;
        if ({dones, reads, viol, drops} !== {32'd1, 32'd5, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL basic%0d_flow got done=%0d reads=%0d viol=%0d drop=%0d want 1/5/0/0",
                     corrupt, dones, reads, viol, drops);
        end
        tests++;
        if (got_pre[0] !== int'(RD_DELAY)) begin
            fails++;
            $display("FAIL basic%0d_delay got=%0d want=%0d", corrupt, got_pre[0], RD_DELAY);
        end
        tests++;
        if ({got_perr[0], got_len[0], got_addr[0]} !== {corrupt, 6'd3, 2'd1}) begin
            fails++;
            $display("FAIL basic%0d_result got perr=%0d len=%0d addr=%0d want %0d/3/1",
                     corrupt, got_perr[0], got_len[0], got_addr[0], corrupt);
        end
        exp_pkt++;
        if (corrupt) exp_err++;
        tests++;
        if ({pkt_cnt, err_cnt} !== stats_model()) begin
            fails++;
            $display("FAIL basic%0d_stats got=%h/%h want=%h", corrupt, pkt_cnt, err_cnt, stats_model());
        end
    endtask

    task automatic test_len0();
        bq_t pl;
        clear_model();
        push_pkt(8'h02, pl, 1'b0);
        run(1, -1, 0, 200);
        tests++;
        if ({dones, reads, viol} !== {32'd1, 32'd2, 32'd0}) begin
            fails++;
            $display("FAIL len0_flow got done=%0d reads=%0d viol=%0d want 1/2/0", dones, reads, viol);
        end
        tests++;
        if ({got_perr[0], got_len[0], got_addr[0]} !== {1'b0, 6'd0, 2'd2}) begin
            fails++;
            $display("FAIL len0_result got perr=%0d len=%0d addr=%0d want 0/0/2",
                     got_perr[0], got_len[0], got_addr[0]);
        end
        exp_pkt++;
    endtask

    task automatic test_stall();
        clear_model();
        push_rand(4, 1'b0);
        run(1, 2, 3, 200);
        tests++;
        if ({dones, reads, viol, stall_seen} !== {32'd1, 32'd6, 32'd0, 32'd3}) begin
            fails++;
            $display("FAIL stall_flow got done=%0d reads=%0d viol=%0d stall=%0d want 1/6/0/3",
                     dones, reads, viol, stall_seen);
        end
        tests++;
        if ({got_perr[0], got_len[0], got_addr[0]} !== {exp_perr[0], exp_len[0], exp_addr[0]}) begin
            fails++;
            $display("FAIL stall_result got perr=%0d len=%0d addr=%0d want %0d/%0d/%0d",
                     got_perr[0], got_len[0], got_addr[0], exp_perr[0], exp_len[0], exp_addr[0]);
        end
        exp_pkt++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            int len;
            len = $urandom_range(0, 24);
            clear_model();
            push_rand(len, 1'($urandom_range(0, 1)));
            run(1, $urandom_range(1, len + 2), $urandom_range(0, 4), 400);
            tests++;
            if ({dones, reads, viol, drops} !== {32'd1, 32'(len + 2), 32'd0, 32'd0}) begin
                fails++;
                $display("FAIL rand%0d_flow got done=%0d reads=%0d viol=%0d drop=%0d want 1/%0d/0/0",
                         k, dones, reads, viol, drops, len + 2);
            end
            tests++;
            if ({got_perr[0], got_len[0], got_addr[0]} !== {exp_perr[0], exp_len[0], exp_addr[0]}) begin
                fails++;
                $display("FAIL rand%0d_result got perr=%0d len=%0d addr=%0d want %0d/%0d/%0d", k,
                         got_perr[0], got_len[0], got_addr[0], exp_perr[0], exp_len[0], exp_addr[0]);
            end
            exp_pkt++;
            if (exp_perr[0]) exp_err++;
        end
        tests++;
        if ({pkt_cnt, err_cnt} !== stats_model()) begin
            fails++;
            $display("FAIL rand_stats got=%h/%h want=%h", pkt_cnt, err_cnt, stats_model());
        end
    endtask

    task automatic test_back_to_back();
        int lens[3];
        int total;
        lens[0] = 63; lens[1] = 0; lens[2] = $urandom_range(1, 20);
        total = 0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            push_rand(lens[i], 1'($urandom_range(0, 1)));
            total += lens[i] + 2;
        end
        run(3, -1, 0, 2000);
        tests++;
        if ({dones, reads, viol} !== {32'd3, 32'(total), 32'd0}) begin
            fails++;
            $display("FAIL b2b_flow got done=%0d reads=%0d viol=%0d want 3/%0d/0",
                     dones, reads, viol, total);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({got_perr[i], got_len[i], got_addr[i], got_pre[i]} !==
                {exp_perr[i], exp_len[i], exp_addr[i], int'(RD_DELAY)}) begin
                fails++;
                $display("FAIL b2b%0d_result got perr=%0d len=%0d addr=%0d wait=%0d want %0d/%0d/%0d/%0d",
                         i, got_perr[i], got_len[i], got_addr[i], got_pre[i],
                         exp_perr[i], exp_len[i], exp_addr[i], RD_DELAY);
            end
            exp_pkt++;
            if (exp_perr[i]) exp_err++;
        end
        tests++;
        if ({got_gap.size(), got_gap[0], got_gap[1]} !== {32'd2, 32'd1, 32'd1}) begin
            fails++;
            $display("FAIL b2b_gap got n=%0d gaps=%0d,%0d want 2 gaps of 1",
                     got_gap.size(), got_gap[0], got_gap[1]);
        end
        tests++;
        if ({pkt_cnt, err_cnt} !== stats_model()) begin
            fails++;
            $display("FAIL b2b_stats got=%h/%h want=%h", pkt_cnt, err_cnt, stats_model());
        end
    endtask

    // Abort after `abort_after` reads; 3 = mid-payload of len 10, 4 = parity capture of len 2.
    task automatic test_soft_rst(input int len, input int abort_after);
        int  n;
        bit  done_at_abort;
        clear_model();
        push_rand(len, 1'b0);
        reads = 0; viol = 0; n = 0;
        while (reads < abort_after && n < 200) begin
            cycle();
            n++;
        end
        soft_rst = 1;
        cycle();
        done_at_abort = done_s;
        soft_rst = 0;
        cycle();
        tests++;
        if ({drop_s, busy_s, done_s, done_at_abort} !== 4'b1000) begin
            fails++;
            $display("FAIL srst%0d_drop got drop=%0d busy=%0d done=%0d/%0d want 1/0/0/0",
                     len, drop_s, busy_s, done_at_abort, done_s);
        end
        dones = 0; drops = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (done_s) dones++;
            if (drop_s) drops++;
        end
        tests++;
        if ({dones, drops, viol} !== {32'd0, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL srst%0d_after got done=%0d drop=%0d viol=%0d want 0/0/0",
                     len, dones, drops, viol);
        end
        tests++;
        if ({pkt_cnt, err_cnt} !== stats_model()) begin
            fails++;
            $display("FAIL srst%0d_stats got=%h/%h want=%h", len, pkt_cnt, err_cnt, stats_model());
        end
    endtask

    task automatic test_rst_mid();
        int n;
        clear_model();
        push_rand(8, 1'b0);
        reads = 0; n = 0;
        while (reads < 4 && n < 200) begin
            cycle();
            n++;
        end
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        exp_pkt = 0; exp_err = 0;
        tests++;
        if ({rd_s, busy_s, done_s, perr_s, drop_s, len_s, addr_s} !== 13'h0) begin
            fails++;
            $display("FAIL rstmid_outputs got rd=%0d busy=%0d done=%0d perr=%0d drop=%0d len=%0d addr=%0d want all 0",
                     rd_s, busy_s, done_s, perr_s, drop_s, len_s, addr_s);
        end
        tests++;
        if ({pkt_cnt, err_cnt} !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_stats got=%h/%h want 0/0", pkt_cnt, err_cnt);
        end
        clear_model();
        push_rand(5, 1'b0);
        run(1, -1, 0, 200);
        tests++;
        if ({dones, reads, viol, got_perr[0], got_len[0], got_addr[0]} !==
            {32'd1, 32'd7, 32'd0, 1'b0, 6'd5, exp_addr[0]}) begin
            fails++;
            $display("FAIL rstmid_clean got done=%0d reads=%0d viol=%0d perr=%0d len=%0d addr=%0d want 1/7/0/0/5/%0d",
                     dones, reads, viol, got_perr[0], got_len[0], got_addr[0], exp_addr[0]);
        end
        exp_pkt++;
        tests++;
        if ({pkt_cnt, err_cnt} !== stats_model()) begin
            fails++;
            $display("FAIL rstmid_clean_stats got=%h/%h want=%h", pkt_cnt, err_cnt, stats_model());
        end
    endtask

    initial begin
        rst = 1; soft_rst = 0; vld_out = 0; data_out = '0; stall = 0;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_len0();
        test_stall();
        test_random();
        test_back_to_back();
        test_soft_rst(10, 3);
        test_soft_rst(2, 4);
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
